// File: rtl/poly_horner_eval_if.sv
// Operand-entry / result bundle for poly_horner_eval.
// POLY_SATURATE_EN adds the sat_flag status line.
interface poly_horner_eval_if #(
  parameter int unsigned WIDTH = 8
);
  logic             go;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_result;
  logic             busy;
  logic             done;
  logic [4:0]       load_idx;
`ifdef POLY_SATURATE_EN
  logic             sat_flag;

  modport master (
    output go, data_in,
    input  data_result, busy, done, load_idx, sat_flag
  );
  modport slave (
    input  go, data_in,
    output data_result, busy, done, load_idx, sat_flag
  );
`else
  modport master (
    output go, data_in,
    input  data_result, busy, done, load_idx
  );
  modport slave (
    input  go, data_in,
    output data_result, busy, done, load_idx
  );
`endif
endinterface

// File: rtl/poly_horner_eval.sv
// Serial-load Horner polynomial evaluator on one shared multiply/add ALU.
// Optional macro POLY_SATURATE_EN: clamp products/sums instead of wrapping, adds sat_flag.
module poly_horner_eval #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEGREE = 2
) (
  input  logic               clk,
  input  logic               resetn,
  poly_horner_eval_if.slave  bus
);

  typedef enum logic [2:0] {StLoad, StLoadWait, StMul, StAdd, StDone} state_e;

  localparam logic [4:0] IdxX   = 5'd31;
  localparam logic [4:0] IdxTop = 5'(DEGREE);
  localparam logic [3:0] KTop   = 4'((DEGREE == 0) ? 0 : DEGREE - 1);

  state_e           state_q;
  logic [4:0]       idx_q;
  logic [3:0]       k_q;
  logic [WIDTH-1:0] coef_q [DEGREE+1];
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] coef_k;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] sum_res;

  always_comb begin
    coef_k = '0;
    for (int i = 0; i < int'(DEGREE); i++) begin
      if (k_q == 4'(i)) coef_k = coef_q[i];
    end
  end

`ifdef POLY_SATURATE_EN
  logic                 sat_q;
  logic [2*WIDTH-1:0]   mul_full;
  logic [WIDTH:0]       sum_full;
  logic                 mul_ovf;
  logic                 sum_ovf;

  assign mul_full = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, x_q};
  assign sum_full = {1'b0, acc_q} + {1'b0, coef_k};
  assign mul_ovf  = |mul_full[2*WIDTH-1:WIDTH];
  assign sum_ovf  = sum_full[WIDTH];
  assign mul_res  = mul_ovf ? '1 : mul_full[WIDTH-1:0];
  assign sum_res  = sum_ovf ? '1 : sum_full[WIDTH-1:0];
  assign bus.sat_flag = sat_q;
`else
  // Assignment context is WIDTH bits, so both results wrap modulo 2^WIDTH.
  assign mul_res = acc_q * x_q;
  assign sum_res = acc_q + coef_k;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StLoad;
      idx_q    <= IdxTop;
      k_q      <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i <= int'(DEGREE); i++) coef_q[i] <= '0;
`ifdef POLY_SATURATE_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          // Keep tracking data_in until the press; the value on the go cycle sticks.
          if (idx_q == IdxX) begin
            x_q <= bus.data_in;
          end else begin
            for (int i = 0; i <= int'(DEGREE); i++) begin
              if (idx_q == 5'(i)) coef_q[i] <= bus.data_in;
            end
          end
          if (bus.go) state_q <= StLoadWait;
        end
        StLoadWait: begin
          if (!bus.go) begin
            if (idx_q == IdxX) begin
              if (DEGREE == 0) begin
                acc_q    <= coef_q[0];
                result_q <= coef_q[0];
                done_q   <= 1'b1;
                state_q  <= StDone;
              end else begin
                acc_q   <= coef_q[DEGREE];
                k_q     <= KTop;
                busy_q  <= 1'b1;
                state_q <= StMul;
              end
            end else if (idx_q == 5'd0) begin
              idx_q   <= IdxX;
              state_q <= StLoad;
            end else begin
              idx_q   <= idx_q - 5'd1;
              state_q <= StLoad;
            end
          end
        end
        StMul: begin
          acc_q   <= mul_res;
          state_q <= StAdd;
`ifdef POLY_SATURATE_EN
          if (mul_ovf) sat_q <= 1'b1;
`endif
        end
        StAdd: begin
          acc_q <= sum_res;
`ifdef POLY_SATURATE_EN
          if (sum_ovf) sat_q <= 1'b1;
`endif
          if (k_q == 4'd0) begin
            // Result and done land together so done marks the write.
            result_q <= sum_res;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StDone;
          end else begin
            k_q     <= k_q - 4'd1;
            state_q <= StMul;
          end
        end
        StDone: begin
          idx_q   <= IdxTop;
          state_q <= StLoad;
`ifdef POLY_SATURATE_EN
          sat_q   <= 1'b0;
`endif
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign bus.data_result = result_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.load_idx    = idx_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// Scoreboard bench for poly_horner_eval: three instances (D=2, D=0, D=3), WIDTH=8.
// Stimulus pushes expected results; a posedge+1 monitor pops and compares on done.
module tb_poly_horner_eval;

  typedef struct {
    logic [7:0] val;
    int         cyc;
    int         busy_cycles;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn_s [3];
  logic       go_s   [3];
  logic [7:0] din_s  [3];
  logic [7:0] res_s  [3];
  logic       busy_s [3];
  logic       done_s [3];
  logic [4:0] lidx_s [3];
  logic       sat_s  [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t       q0 [$];
  exp_t       q1 [$];
  exp_t       q2 [$];
  logic [7:0] last_res [3];
  int         bcnt     [3];
  logic [7:0] ops      [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    poly_horner_eval_if #(.WIDTH(8)) bus ();
    assign bus.go      = go_s[g];
    assign bus.data_in = din_s[g];
    assign res_s[g]    = bus.data_result;
    assign busy_s[g]   = bus.busy;
    assign done_s[g]   = bus.done;
    assign lidx_s[g]   = bus.load_idx;
`ifdef POLY_SATURATE_EN
    assign sat_s[g]    = bus.sat_flag;
`else
    assign sat_s[g]    = 1'b0;
`endif
    poly_horner_eval #(.WIDTH(8), .DEGREE(D)) u_dut (
      .clk    (clk),
      .resetn (rstn_s[g]),
      .bus    (bus)
    );
  end

  function automatic int deg(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_done(input int i);
    exp_t e;
    int   have;
    have = (qsize(i) != 0) ? 1 : 0;
    chk($sformatf("done_expected[%0d]", i), have, 1);
    if (have == 0) begin
      last_res[i] = res_s[i];
    end else begin
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("result[%0d]", i), res_s[i], e.val);
      chk($sformatf("done_cycle[%0d]", i), cyc, e.cyc);
      chk($sformatf("busy_cycles[%0d]", i), bcnt[i], e.busy_cycles);
`ifdef POLY_SATURATE_EN
      chk($sformatf("sat_flag[%0d]", i), sat_s[i], e.sat);
`endif
      last_res[i] = e.val;
    end
    bcnt[i] = 0;
  endtask

  // Monitor: result must hold between done pulses; done pops the scoreboard.
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rstn_s[i]) begin
        last_res[i] = 8'h00;
        bcnt[i]     = 0;
      end
      if (done_s[i] === 1'b1) check_done(i);
      else chk($sformatf("result_hold[%0d]", i), res_s[i], last_res[i]);
      if (busy_s[i] === 1'b1) bcnt[i]++;
    end
  end

  task automatic press(input int i, input logic [7:0] v, input int hold, input logic [4:0] idx);
    @(negedge clk);
    chk($sformatf("load_idx[%0d]", i), lidx_s[i], idx);
    din_s[i] = v;
    go_s[i]  = 1'b1;
    repeat (hold) @(negedge clk);
    go_s[i]  = 1'b0;
  endtask

  task automatic load(input int i, input int first, input int last, input int hold);
    for (int j = first; j <= last; j++) begin
      press(i, ops[j], hold, (j <= deg(i)) ? 5'(deg(i) - j) : 5'd31);
    end
  endtask

  // Called at the x-release edge: done is due 2*D+1 cycles later.
  task automatic expect_done(input int i, input logic [7:0] v, input logic s);
    exp_t e;
    e.val         = v;
    e.cyc         = cyc + 2 * deg(i) + 1;
    e.busy_cycles = 2 * deg(i);
    e.sat         = s;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic wait_drain(input int i);
    int n = 0;
    while (qsize(i) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain[%0d]", i), qsize(i), 0);
  endtask

  initial begin
    logic [7:0] wrap_val;
    logic       wrap_sat;
`ifdef POLY_SATURATE_EN
    wrap_val = 8'hFF;
    wrap_sat = 1'b1;
`else
    wrap_val = 8'h00;
    wrap_sat = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      rstn_s[i]   = 1'b0;
      go_s[i]     = 1'b0;
      din_s[i]    = 8'h00;
      last_res[i] = 8'h00;
      bcnt[i]     = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_result[%0d]", i), res_s[i], 8'h00);
      chk($sformatf("rst_busy[%0d]", i), busy_s[i], 1'b0);
      chk($sformatf("rst_done[%0d]", i), done_s[i], 1'b0);
      chk($sformatf("rst_load_idx[%0d]", i), lidx_s[i], 5'(deg(i)));
      rstn_s[i] = 1'b1;
    end

    // D=2: 2x^2+3x+1 at x=3 = 28
    ops = '{8'd2, 8'd3, 8'd1, 8'd3, 8'd0};
    load(0, 0, 3, 1);
    expect_done(0, 8'h1C, 1'b0);
    wait_drain(0);

    // D=2: x^2 at x=16 overflows
    ops = '{8'd1, 8'd0, 8'd0, 8'd16, 8'd0};
    load(0, 0, 3, 1);
    expect_done(0, wrap_val, wrap_sat);
    wait_drain(0);

    // D=0: constant polynomial, done one cycle after x release
    ops = '{8'hA5, 8'h07, 8'd0, 8'd0, 8'd0};
    load(1, 0, 1, 1);
    expect_done(1, 8'hA5, 1'b0);
    wait_drain(1);

    // D=3: all-ones coefficients at x=2, go held 10 cycles per operand
    ops = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
    load(2, 0, 4, 10);
    expect_done(2, 8'h0F, 1'b0);
    wait_drain(2);

    // D=2: reset during the first multiply discards the evaluation
    ops = '{8'd2, 8'd3, 8'd1, 8'd3, 8'd0};
    load(0, 0, 3, 1);
    @(negedge clk);
    chk("busy_in_mul", busy_s[0], 1'b1);
    rstn_s[0] = 1'b0;
    @(negedge clk);
    rstn_s[0] = 1'b1;
    chk("midrst_result", res_s[0], 8'h00);
    chk("midrst_busy", busy_s[0], 1'b0);
    chk("midrst_done", done_s[0], 1'b0);
    chk("midrst_load_idx", lidx_s[0], 5'd2);
    repeat (8) @(negedge clk);
    load(0, 0, 3, 1);
    expect_done(0, 8'h1C, 1'b0);
    wait_drain(0);

    // Partial reload keeps 0x1C; go pulsed during compute is ignored. x^2+2x+3 at 2 = 11
    ops = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd0};
    load(0, 0, 1, 1);
    @(negedge clk);
    chk("partial_result", res_s[0], 8'h1C);
    load(0, 2, 3, 1);
    expect_done(0, 8'h0B, 1'b0);
    @(negedge clk);
    go_s[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    go_s[0] = 1'b0;
    wait_drain(0);

    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("final_queue[%0d]", i), qsize(i), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/poly_horner_eval.md
Name: poly_horner_eval

Overview:
Parametrised successor to the fixed second-order polynomial unit. It evaluates p(x) = c[D]*x^D + ... + c[1]*x + c[0] of configurable degree D and data width using Horner's rule: one multiply and one add per coefficient on a single shared ALU. Operands are entered serially through the same go / data_in press-release handshake the board top-levels already drive. The result goes to a held result register plus done/busy status, which feeds LEDR/HEX through the existing hex_decoder.

Parameters:
WIDTH, 8, datapath width of coefficients, x, accumulator and result; legal 4..16
DEGREE, 2, polynomial degree D; legal 0..15; D+1 coefficient registers

Ports:
clk  in  1  system clock, all logic on posedge
resetn  in  1  synchronous active-low reset, sampled on posedge clk
go  in  1  active-high load strobe (top level drives ~KEY[1])
data_in  in  WIDTH  coefficient / x operand
data_result  out  WIDTH  last completed p(x), held until the next completion
busy  out  1  high while evaluating (S_MUL / S_ADD)
done  out  1  one-cycle pulse when data_result is written
load_idx  out  5  index of the operand being loaded: D..0 = coefficient c[idx], 31 = x

Behaviour:
- Reset (resetn=0 at posedge): state=S_LOAD, idx=D, all coefficients, x, acc and data_result = 0, busy=0, done=0. Applies identically mid-load or mid-compute; partial results are discarded.
- Load order: c[D] first, down to c[0], then x. Total D+2 operands.
- S_LOAD: the target register captures data_in on every cycle.
  - go=1 -> S_LOAD_WAIT. The value present on that cycle is the one kept.
- S_LOAD_WAIT: holds, no capture.
  - go=0: if idx > 0, idx <= idx-1 and go to S_LOAD.
  - go=0 and idx = 0: idx <= 31 (x) and go to S_LOAD.
  - go=0 while x was the target: acc <= c[D], k <= D-1, go to S_MUL. If D=0, go straight to S_DONE with acc = c[0].
- S_MUL (1 cycle): acc <= acc * x, then S_ADD.
- S_ADD (1 cycle): acc <= acc + c[k].
  - k = 0 -> S_DONE; otherwise k <= k-1 and go to S_MUL.
- S_DONE (1 cycle): data_result <= acc, done=1, idx <= D, then S_LOAD.
- Latency: 2*D+1 cycles from the first cycle after the x release to the done pulse. D=2 gives 5 cycles.
- busy=1 exactly in S_MUL and S_ADD. go is ignored during compute and S_DONE; holding go through S_DONE starts the next S_LOAD and will immediately advance on go=1.
- Arithmetic: unsigned, keep the low WIDTH bits of each product and sum (modulo 2^WIDTH). The multiply is a WIDTH x WIDTH product truncated to WIDTH bits.
- Coefficients and x persist after completion, but every evaluation reloads all D+2 operands.
- data_result changes only in S_DONE or on reset.
- load_idx is combinational from the state/idx registers and is valid in S_LOAD and S_LOAD_WAIT. In other states it holds its last value.

Optional Feature:
POLY_SATURATE_EN
- Defined: every product and sum is computed at 2*WIDTH bits and clamped to 2^WIDTH-1 when it overflows. Adds output sat_flag (1 bit): cleared in S_DONE setup and on reset, sticky for the evaluation, and valid with done.
- Undefined: modulo-2^WIDTH wrap as above, and no sat_flag port.

Test Plan:
- WIDTH=8, D=2; load c2=2, c1=3, c0=1, x=3 with a clean press/release each -> done pulses 5 cycles after the x release; data_result=0x1C (28); busy high for exactly 4 cycles.
- Same bench, c2=1, c1=0, c0=0, x=16 -> data_result=0x00 (wrap). With POLY_SATURATE_EN: data_result=0xFF and sat_flag=1.
- D=0, load c0=0xA5 then x=0x07 -> done the cycle after the x release; data_result=0xA5.
- D=3, WIDTH=8; c=1,1,1,1 (c3..c0), x=2; hold go for 10 cycles per operand -> exactly one capture per press; data_result=0x0F; load_idx steps 3,2,1,0,31.
- Assert resetn=0 for one cycle while in S_MUL of a D=2 evaluation -> data_result=0, busy=0, no done pulse, load_idx=2; a following full load of 2,3,1,3 gives 0x1C.
- After a result of 0x1C, pulse go during compute and load a new set partway -> data_result stays 0x1C until the next done pulse.
